// File: rtl/riscv_regfile_wbdly.sv
// riscv_regfile_wbdly: 32x32 register file whose write address is delayed WB_DELAY cycles; define REGFILE_BYPASS_EN for write-to-read forwarding
module riscv_regfile_wbdly #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int WB_DELAY = 3,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   AddrA_i,
    input  logic [AW-1:0]   AddrB_i,
    input  logic [AW-1:0]   AddrD_i,
    input  logic [XLEN-1:0] DataD_i,
    input  logic            RegWEn_i,
    output logic [XLEN-1:0] DataA_o,
    output logic [XLEN-1:0] DataB_o
);
    logic [AW-1:0]   dly_q [WB_DELAY];
    logic [AW-1:0]   dly_d [WB_DELAY];
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [AW-1:0]   waddr;
    logic            wr_en;

    assign waddr = dly_q[WB_DELAY-1];
    assign wr_en = RegWEn_i && (waddr != '0);

    // shift the destination address along so it meets its write-back data
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = AddrD_i;
        for (int i = 1; i < WB_DELAY; i++) dly_d[i] = dly_q[i-1];
    end

    // commit write-back data; x0 is forced back to zero so it can never hold a value
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = DataD_i;
        regs_d[0] = '0;
    end

    // state registers; reset empties the delay line so in-flight addresses are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q  <= '{default: '0};
            regs_q <= '{default: '0};
        end else begin
            dly_q  <= dly_d;
            regs_q <= regs_d;
        end
    end

    // combinational read ports, optionally forwarding the write in progress
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        DataA_o = (AddrA_i == '0) ? '0 : (wr_en && AddrA_i == waddr) ? DataD_i : regs_q[AddrA_i];
        DataB_o = (AddrB_i == '0) ? '0 : (wr_en && AddrB_i == waddr) ? DataD_i : regs_q[AddrB_i];
`else
        DataA_o = (AddrA_i == '0) ? '0 : regs_q[AddrA_i];
        DataB_o = (AddrB_i == '0) ? '0 : regs_q[AddrB_i];
`endif
    end
endmodule

// File: tb/tb_riscv_regfile_wbdly.sv
// tb_riscv_regfile_wbdly: directed vector table plus randomized run against a register-file model
module tb_riscv_regfile_wbdly;
    localparam int WBD = 3;
`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_CYC = 32'd18;
`else
    localparam logic [31:0] SAME_CYC = 32'd0;
`endif

    logic        clk_i = 0, rst_i = 1, RegWEn_i = 0;
    logic [4:0]  AddrA_i = 0, AddrB_i = 0, AddrD_i = 0;
    logic [31:0] DataD_i = 0, DataA_o, DataB_o;
    int n_chk = 0, n_fail = 0;

    riscv_regfile_wbdly #(.XLEN(32), .NREGS(32), .WB_DELAY(WBD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .AddrA_i(AddrA_i), .AddrB_i(AddrB_i),
        .AddrD_i(AddrD_i), .DataD_i(DataD_i), .RegWEn_i(RegWEn_i),
        .DataA_o(DataA_o), .DataB_o(DataB_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst, wen;
        logic [4:0]  ad, aa, ab;
        logic [31:0] dd, ea, eb;
    } vec_t;
    vec_t tbl[14];

    logic [31:0] model [32];
    logic [4:0]  hist [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (model[i]) model[i] = 0;
        hist = {};
        repeat (WBD) hist.push_back(5'd0);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [4:0] wa = hist[0];
        if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (RegWEn_i && wa != 0 && a == wa) return DataD_i;
`endif
        return model[a];
    endfunction

    initial begin
        tbl[0]  = '{0, 0, 5'd2, 5'd0, 5'd1, 32'd0,  32'd0,  32'd0};
        tbl[1]  = '{0, 0, 5'd3, 5'd0, 5'd1, 32'd0,  32'd0,  32'd0};
        tbl[2]  = '{0, 0, 5'd8, 5'd0, 5'd1, 32'd0,  32'd0,  32'd0};
        tbl[3]  = '{0, 1, 5'd4, 5'd0, 5'd1, 32'd16, 32'd0,  32'd0};
        tbl[4]  = '{0, 0, 5'd0, 5'd2, 5'd1, 32'd0,  32'd16, 32'd0};
        tbl[5]  = '{0, 1, 5'd0, 5'd2, 5'd8, 32'd18, 32'd16, SAME_CYC};
        tbl[6]  = '{0, 0, 5'd0, 5'd8, 5'd8, 32'd0,  32'd18, 32'd18};
        tbl[7]  = '{0, 1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
        tbl[8]  = '{0, 0, 5'd5, 5'd0, 5'd8, 32'd0,  32'd0,  32'd18};
        tbl[9]  = '{1, 1, 5'd0, 5'd8, 5'd2, 32'd55, 32'd0,  32'd0};
        tbl[10] = '{0, 1, 5'd0, 5'd5, 5'd5, 32'd99, 32'd0,  32'd0};
        tbl[11] = '{0, 1, 5'd0, 5'd5, 5'd5, 32'd99, 32'd0,  32'd0};
        tbl[12] = '{0, 1, 5'd0, 5'd5, 5'd5, 32'd99, 32'd0,  32'd0};
        tbl[13] = '{0, 0, 5'd0, 5'd8, 5'd5, 32'd0,  32'd0,  32'd0};

        AddrA_i = 5'd3; AddrB_i = 5'd31;
        #1;
        chk("reset_a", DataA_o, 32'd0);
        chk("reset_b", DataB_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 0;

        for (int i = 0; i < 14; i++) begin
            rst_i = tbl[i].rst; RegWEn_i = tbl[i].wen; AddrD_i = tbl[i].ad;
            DataD_i = tbl[i].dd; AddrA_i = tbl[i].aa; AddrB_i = tbl[i].ab;
            #1;
            chk($sformatf("vec%0d_a", i), DataA_o, tbl[i].ea);
            chk($sformatf("vec%0d_b", i), DataB_o, tbl[i].eb);
            @(posedge clk_i); #1;
        end

        rst_i = 1; RegWEn_i = 0;
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 0;
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wa;
            rst_i    = ($urandom_range(0, 59) == 0);
            RegWEn_i = $urandom_range(0, 3) != 0;
            AddrD_i  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            DataD_i  = $urandom;
            AddrA_i  = 5'($urandom_range(0, 31));
            AddrB_i  = ($urandom_range(0, 3) == 0) ? AddrA_i : 5'($urandom_range(0, 31));
            if (rst_i) model_reset();
            else if ($urandom_range(0, 2) == 0) AddrA_i = hist[0];
            #1;
            chk("rand_a", DataA_o, model_read(AddrA_i));
            chk("rand_b", DataB_o, model_read(AddrB_i));
            @(posedge clk_i); #1;
            if (!rst_i) begin
                wa = hist.pop_front();
                if (RegWEn_i && wa != 0) model[wa] = DataD_i;
                hist.push_back(AddrD_i);
            end
        end
        rst_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
